// File: rtl/hazard_pipe_regs_pkg.sv
// Shared definitions for the front-end pipeline registers.
//   NOP_INSTR      : canonical bubble instruction (addi x0, x0, 0)
//   CTRL_W_DEF     : default width of the packed decode control word
//   CTRL_*         : bit positions of the fields inside the control word
//   IFID_W         : width of the packed IF/ID register contents
package hazard_pipe_regs_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          CTRL_W_DEF = 11;

  // Control word layout, MSB first.
  localparam int CTRL_REGWRITE     = 10;
  localparam int CTRL_RESULTSRC_HI = 9;
  localparam int CTRL_RESULTSRC_LO = 8;
  localparam int CTRL_MEMWRITE     = 7;
  localparam int CTRL_JUMP         = 6;
  localparam int CTRL_BRANCH       = 5;
  localparam int CTRL_ALUCTRL_HI   = 4;
  localparam int CTRL_ALUCTRL_LO   = 2;
  localparam int CTRL_ALUSRC       = 1;
  localparam int CTRL_SPARE        = 0;

  // IF/ID payload: instruction, PC and PC+4 of the fetched instruction.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;

  localparam int    IFID_W     = $bits(ifid_t);
  localparam ifid_t IFID_EMPTY = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};

endpackage

// File: rtl/hazard_pipe_regs_pipe_reg.sv
// Generic pipeline register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, loads RST_VAL
//   en   : load d_i when 1, hold when 0
//   clr  : synchronous clear to CLR_VAL, wins over en
//   d_i  : next data
//   q_o  : registered data
module pipe_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VAL;
    end else if (en) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/hazard_pipe_regs.sv
// Front-end pipeline state of the 5-stage RISC-V core: PC (F), IF/ID (D)
// and ID/EX (E) registers driven by the hazard unit's stall/flush commands,
// plus free-running stall/flush event counters for performance debug.
// Ports:
//   clk, reset                       clock, async active-high reset
//   StallF, StallD, FlushD, FlushE   hazard-unit commands
//   PCNextF, InstrF, PCPlus4F        fetch-stage inputs
//   PCF                              current fetch PC
//   InstrD, PCD, PCPlus4D            decode-stage registered values
//   CtrlD, RD1D, RD2D, ImmExtD,
//   Rs1D, Rs2D, RdD                  decode-stage inputs to ID/EX
//   CtrlE, RD1E, RD2E, ImmExtE, PCE,
//   PCPlus4E, Rs1E, Rs2E, RdE        execute-stage registered values
//   StallCount, FlushCount           cycles with StallF / FlushE high
module hazard_pipe_regs
  import hazard_pipe_regs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = CTRL_W_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [31:0]       PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       PCPlus4F,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       ImmExtD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       ImmExtE,
  output logic [31:0]       PCE,
  output logic [31:0]       PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int IDEX_W = CTRL_W + 5 * 32 + 3 * 5;

  // ---------------- F stage: program counter ----------------
  pipe_reg #(
    .W       (32),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (reset),
    .en  (~StallF),
    .clr (1'b0),
    .d_i (PCNextF),
    .q_o (PCF)
  );

  // ---------------- F -> D boundary: IF/ID ----------------
  ifid_t ifid_d;
  ifid_t ifid_q;

  always_comb begin
    ifid_d          = IFID_EMPTY;
    ifid_d.instr    = InstrF;
    ifid_d.pc       = PCF;
    ifid_d.pc_plus4 = PCPlus4F;
  end

  // A flushed IF/ID slot holds a NOP rather than all-zeros, so the decoder
  // sees a legal instruction with rd = x0.
  pipe_reg #(
    .W       (IFID_W),
    .RST_VAL (IFID_EMPTY),
    .CLR_VAL (IFID_EMPTY)
  ) u_ifid_reg (
    .clk (clk),
    .rst (reset),
    .en  (~StallD),
    .clr (FlushD),
    .d_i (ifid_d),
    .q_o (ifid_q)
  );

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;

  // ---------------- D -> E boundary: ID/EX ----------------
  logic [IDEX_W-1:0] idex_d;
  logic [IDEX_W-1:0] idex_q;

  assign idex_d = {CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};

  // The E stage never stalls; a bubble zeroes every field, including the
  // register indices, so it can never match a forwarding or load-use compare.
  pipe_reg #(
    .W       (IDEX_W),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_idex_reg (
    .clk (clk),
    .rst (reset),
    .en  (1'b1),
    .clr (FlushE),
    .d_i (idex_d),
    .q_o (idex_q)
  );

  assign {CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = idex_q;

  // ---------------- Event counters (wrap, no saturation) ----------------
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  assign stall_cnt_d = stall_cnt_q + CNT_W'(StallF);
  assign flush_cnt_d = flush_cnt_q + CNT_W'(FlushE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule
